lr_sample_streamer: RTL and testbench

LR_SAMPLE_STREAMER -- requirements
Module: lr_sample_streamer

---
 rtl/lr_sample_streamer.sv | 176 +++++++++++++++++
 tb/tb_lr_sample_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lr_sample_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lr_sample_streamer : replays a 16-entry {X,Y} buffer into a Linear_Regression
//                      core under its busy handshake and captures the results.
// Revision 1.0
// ----------------------------------------------------------------------------
module lr_sample_streamer #(
    parameter int N_SAMPLES = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_addr_i,
    input  logic [15:0] wr_x_i,
    input  logic [15:0] wr_y_i,
    input  logic        start_i,
    input  logic        busy_i,
    input  logic [31:0] b1_i,
    input  logic [31:0] b0_i,
    input  logic [31:0] mse_i,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic        valid_o,
    output logic [31:0] res_b1_o,
    output logic [31:0] res_b0_o,
    output logic [31:0] res_mse_o,
    output logic        active_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [3:0] LAST_IDX    = 4'(N_SAMPLES - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] res_b1_q, res_b1_d, res_b0_q, res_b0_d, res_mse_q, res_mse_d;

    logic [15:0] buf_x_q [16];
    logic [15:0] buf_y_q [16];

    logic [7:0]  cnt_inc;
    logic        timeout_hit;

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    // Sample storage is deliberately left out of reset so it survives across runs.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (state_q == S_IDLE)) begin
            buf_x_q[wr_addr_i] <= wr_x_i;
            buf_y_q[wr_addr_i] <= wr_y_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_i) state_d = S_SEND;
            S_SEND:      if (!busy_i && (idx_q == LAST_IDX)) state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (busy_i) state_d = S_WAIT_DONE;
                         else if (timeout_hit) state_d = S_DONE;
            S_WAIT_DONE: if (!busy_i || timeout_hit) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active_o = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
    end

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        res_b1_d  = res_b1_q;
        res_b0_d  = res_b0_q;
        res_mse_d = res_mse_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d = 4'd0;
                    cnt_d = 8'd0;
                    err_d = 1'b0;
                end
            end
            S_SEND: begin
                if (!busy_i) begin
                    x_d     = buf_x_q[idx_q];
                    y_d     = buf_y_q[idx_q];
                    valid_d = 1'b1;
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT_BUSY: begin
                if (busy_i) begin
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) err_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                // A falling busy wins over a simultaneous timeout.
                if (!busy_i) begin
                    res_b1_d  = b1_i;
                    res_b0_d  = b0_i;
                    res_mse_d = mse_i;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q     <= 4'd0;
            cnt_q     <= 8'd0;
            x_q       <= 16'd0;
            y_q       <= 16'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            res_b1_q  <= 32'd0;
            res_b0_q  <= 32'd0;
            res_mse_q <= 32'd0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            res_b1_q  <= res_b1_d;
            res_b0_q  <= res_b0_d;
            res_mse_q <= res_mse_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign res_b1_o  = res_b1_q;
    assign res_b0_o  = res_b0_q;
    assign res_mse_o = res_mse_q;

endmodule
`default_nettype wire

// File: tb/tb_lr_sample_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lr_sample_streamer : table-driven and randomized runs of lr_sample_streamer
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_lr_sample_streamer;

    localparam int N  = 16;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en_i;
    logic [3:0]  wr_addr_i;
    logic [15:0] wr_x_i, wr_y_i;
    logic        start_i, busy_i;
    logic [31:0] b1_i, b0_i, mse_i;
    logic [15:0] x_o, y_o;
    logic        valid_o, active_o, done_o, err_o;
    logic [31:0] res_b1_o, res_b0_o, res_mse_o;

    always #5 clk = ~clk;

    lr_sample_streamer #(.N_SAMPLES(N), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_x_i(wr_x_i), .wr_y_i(wr_y_i),
        .start_i(start_i), .busy_i(busy_i),
        .b1_i(b1_i), .b0_i(b0_i), .mse_i(mse_i),
        .x_o(x_o), .y_o(y_o), .valid_o(valid_o),
        .res_b1_o(res_b1_o), .res_b0_o(res_b0_o), .res_mse_o(res_mse_o),
        .active_o(active_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        int          stall_at;   // stall after this many pairs (0 = none)
        int          stall_len;
        int          post_busy;  // busy-high cycles after the last pair (0 = never)
        bit          inject;     // pulse start + wr_en mid-SEND
        logic [31:0] b1, b0, mse;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_b1, exp_b0, exp_mse;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] mx [16];
    logic [15:0] my [16];
    vec_t        vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, x_o, 0);
        chk({tag, "_y"}, y_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_active"}, active_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_b1"}, res_b1_o, 0);
        chk({tag, "_b0"}, res_b0_o, 0);
        chk({tag, "_mse"}, res_mse_o, 0);
    endtask

    task automatic load_buffer();
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; wr_addr_i = 4'(i); wr_x_i = mx[i]; wr_y_i = my[i];
            @(posedge clk); #1;
        end
        wr_en_i = 1'b0;
    endtask

    function automatic vec_t mk(int sa, int sl, int pb, bit inj,
                                logic [31:0] b1, logic [31:0] b0, logic [31:0] mse,
                                int lat, bit e,
                                logic [31:0] eb1, logic [31:0] eb0, logic [31:0] emse);
        vec_t v;
        v.stall_at = sa; v.stall_len = sl; v.post_busy = pb; v.inject = inj;
        v.b1 = b1; v.b0 = b0; v.mse = mse;
        v.exp_lat = lat; v.exp_err = e;
        v.exp_b1 = eb1; v.exp_b0 = eb0; v.exp_mse = emse;
        return v;
    endfunction

    // One full run: expected pairs are the model buffer in order; X/Y must hold between pairs.
    task automatic run_case(input vec_t v, input bit rnd);
        int pulses = 0, last_obs = -1, done_obs = -1, stall_left = 0, post_left = 0;
        bit fin = 1'b0;
        b1_i = v.b1; b0_i = v.b0; mse_i = v.mse;
        busy_i = 1'b0; start_i = 1'b1;
        for (int obs = 1; obs <= 600 && !fin; obs++) begin
            @(posedge clk); #1;
            start_i = 1'b0; wr_en_i = 1'b0;
            if (done_obs >= 0) begin
                chk("done_single_cycle", done_o, 0);
                chk("idle_after_done", active_o, 0);
                fin = 1'b1;
            end else begin
                chk("active_in_run", active_o, 1);
                if (valid_o) begin
                    if (pulses < N) begin
                        chk("pair_x", x_o, mx[pulses]);
                        chk("pair_y", y_o, my[pulses]);
                    end
                    pulses++;
                    last_obs = obs;
                    if (pulses == N) post_left = v.post_busy;
                end else if (pulses > 0) begin
                    chk("hold_x", x_o, mx[pulses-1]);
                    chk("hold_y", y_o, my[pulses-1]);
                end
                if (done_o) done_obs = obs;
                if (pulses < N) begin
                    if (stall_left > 0) begin
                        busy_i = 1'b1; stall_left--;
                    end else if (valid_o && pulses == v.stall_at && v.stall_len > 0) begin
                        busy_i = 1'b1; stall_left = v.stall_len - 1;
                    end else begin
                        busy_i = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
                    end
                end else begin
                    busy_i = (post_left > 0);
                    if (post_left > 0) post_left--;
                end
                if (v.inject && valid_o && pulses == 5) begin
                    start_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 4'd8;
                    wr_x_i = 16'h7fff; wr_y_i = 16'h7fff;
                end
            end
        end
        busy_i = 1'b0;
        if (done_obs < 0) begin
            n_chk++; n_fail++;
            $display("FAIL run_timeout: no done pulse within 600 cycles, pairs seen %0d", pulses);
        end else begin
            chk("pulse_count", pulses, N);
            chk("done_latency", done_obs - last_obs, v.exp_lat);
            chk("err", err_o, v.exp_err);
            chk("res_b1", res_b1_o, v.exp_b1);
            chk("res_b0", res_b0_o, v.exp_b0);
            chk("res_mse", res_mse_o, v.exp_mse);
            if (!rnd) chk("last_pair_cycle", last_obs, N + 1 + v.stall_len);
        end
    endtask

    initial begin
        int dx [16] = '{9, -35, 80, 51, -94, 21, -60, 1, 17, 25, -16, -28, 55, 21, 12, -10};
        int dy [16] = '{5, 89, -64, 32, -15, 77, 45, -11, 19, 27, -15, -10, 44, 20, 11, 5};
        int pulses;
        vec_t rv;
        int pb;

        rst_n = 1'b1; wr_en_i = 1'b0; wr_addr_i = 4'd0; wr_x_i = 16'd0; wr_y_i = 16'd0;
        start_i = 1'b0; busy_i = 1'b0; b1_i = 32'd0; b0_i = 32'd0; mse_i = 32'd0;
        #1 rst_n = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            mx[i] = 16'(dx[i]);
            my[i] = 16'(dy[i]);
        end
        load_buffer();

        vt[0] = mk(0, 0, 5, 0, 32'h100, 32'h10, 32'h400, 6, 0, 32'h100, 32'h10, 32'h400);
        vt[1] = mk(4, 2, 5, 0, 32'h100, 32'h10, 32'h400, 6, 0, 32'h100, 32'h10, 32'h400);
        vt[2] = mk(0, 0, 0, 0, 32'hdead_beef, 32'hcafe_f00d, 32'h1234_5678, TO, 1,
                   32'h100, 32'h10, 32'h400);
        vt[3] = mk(0, 0, 1, 1, 32'h1, 32'h2, 32'h3, 2, 0, 32'h1, 32'h2, 32'h3);
        vt[4] = mk(0, 0, 3, 0, 32'h7, 32'h8, 32'h9, 4, 0, 32'h7, 32'h8, 32'h9);

        for (int i = 0; i < 5; i++) begin
            run_case(vt[i], 1'b0);
            if (i == 2) begin
                repeat (3) @(posedge clk);
                #1;
                chk("err_sticky_in_idle", err_o, 1);
            end
        end

        // Abort a run after seven pairs; reset must clear outputs without waiting for a clock.
        busy_i = 1'b0; start_i = 1'b1; pulses = 0;
        for (int c = 0; c < 50 && pulses < 7; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (valid_o) pulses++;
        end
        chk("midrun_pairs_before_reset", pulses, 7);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_in_reset", done_o, 0);
        chk("idle_in_reset", active_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_case(vt[0], 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                mx[i] = 16'($urandom);
                my[i] = 16'($urandom);
            end
            load_buffer();
            pb = int'($urandom_range(1, 8));
            rv = mk(0, 0, pb, 0, $urandom, $urandom, $urandom, pb + 1, 0, 32'd0, 32'd0, 32'd0);
            rv.exp_b1 = rv.b1; rv.exp_b0 = rv.b0; rv.exp_mse = rv.mse;
            run_case(rv, 1'b1);
        end

        // Replay without reload must reproduce the last random buffer.
        rv.post_busy = 2; rv.exp_lat = 3;
        run_case(rv, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
